// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - hard-decision Viterbi decoder, rate 1/2, K=3 (g0=111, g1=101)
// Register-exchange survivors; one decoded bit per completed symbol after TB_DEPTH-1 symbols.
module viterbi_decoder #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic Clock,
    input  logic reset,
    input  logic in_valid,
    input  logic in,
    output logic out,
    output logic out_valid
);

    localparam logic [PM_W-1:0] PM_MAX   = {PM_W{1'b1}};
    localparam int              CNT_W    = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);

    logic                phase_q, phase_d;
    logic                c0_q, c0_d;
    logic [PM_W-1:0]     pm_q [4];
    logic [PM_W-1:0]     pm_d [4];
    logic [TB_DEPTH-1:0] surv_q [4];
    logic [TB_DEPTH-1:0] surv_d [4];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_q, out_d;
    logic                out_valid_q, out_valid_d;

    logic [PM_W-1:0]     cand [4][2];
    logic [3:0]          win;
    logic [PM_W-1:0]     acs_pm [4];
    logic [TB_DEPTH-1:0] surv_new [4];
    logic [PM_W-1:0]     pm_min;
    logic [1:0]          best;

    function automatic logic [1:0] branch_metric(input logic u, input logic [1:0] s,
                                                 input logic r0, input logic r1);
        logic g0;
        logic g1;
        g0 = u ^ s[1] ^ s[0];
        g1 = u ^ s[0];
        return {1'b0, r0 ^ g0} + {1'b0, r1 ^ g1};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
        logic [PM_W:0] sum;
        sum = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
    endfunction

    // Add-compare-select for all four next states; the received symbol is {c0_q, in}.
    always_comb begin
        logic [1:0] nsb;
        logic [1:0] p0;
        logic [1:0] p1;
        nsb = '0;
        p0  = '0;
        p1  = '0;
        win = '0;
        for (int ns = 0; ns < 4; ns++) begin
            nsb = 2'(ns);
            p0  = {nsb[0], 1'b0};
            p1  = {nsb[0], 1'b1};
            cand[ns][0] = sat_add(pm_q[p0], branch_metric(nsb[1], p0, c0_q, in));
            cand[ns][1] = sat_add(pm_q[p1], branch_metric(nsb[1], p1, c0_q, in));
            // Ties go to the predecessor with LSB 0.
            win[ns]      = cand[ns][1] < cand[ns][0];
            acs_pm[ns]   = win[ns] ? cand[ns][1] : cand[ns][0];
            surv_new[ns] = {surv_q[{nsb[0], win[ns]}][TB_DEPTH-2:0], nsb[1]};
        end
        pm_min = acs_pm[0];
        best   = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (acs_pm[i] < pm_min) begin
                pm_min = acs_pm[i];
                best   = 2'(i);
            end
        end
    end

    always_comb begin
        phase_d     = phase_q;
        c0_d        = c0_q;
        pm_d        = pm_q;
        surv_d      = surv_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            if (!phase_q) begin
                c0_d    = in;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    pm_d[i]   = acs_pm[i] - pm_min;
                    surv_d[i] = surv_new[i];
                end
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_d == CNT_FULL) begin
                    out_valid_d = 1'b1;
                    out_d       = surv_new[best][TB_DEPTH-1];
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            phase_q     <= 1'b0;
            c0_q        <= 1'b0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_MAX;
                surv_q[i] <= '0;
            end
        end else begin
            phase_q     <= phase_d;
            c0_q        <= c0_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= pm_d[i];
                surv_q[i] <= surv_d[i];
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - randomized bench for viterbi_decoder against a traceback reference model
// Directed scenarios plus a 10k-bit loopback with sparse injected channel errors.
module tb_viterbi_decoder;

    localparam int TB = 16;
    localparam int PW = 6;
    localparam int PMAX = (1 << PW) - 1;

    logic Clock = 1'b0;
    logic reset;
    logic in_valid;
    logic in_bit;
    logic out_bit;
    logic out_valid;

    viterbi_decoder #(.TB_DEPTH(TB), .PM_W(PW)) dut (
        .Clock     (Clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in_bit),
        .out       (out_bit),
        .out_valid (out_valid)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    int m_pm [4];
    int m_dec [$];
    int m_cnt;
    int m_n;
    bit m_phase;
    bit m_c0;
    bit m_out;
    bit m_outv;
    bit truth_q [$];
    bit seen_q [$];
    int n_pulse;
    bit enc1;
    bit enc2;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: per-symbol winner decisions kept as history, output found by tracing back.
    task automatic model_symbol(input bit c0, input bit c1);
        int cand [2];
        int npm [4];
        int d;
        int mn;
        int best;
        int s;
        d = 0;
        for (int ns = 0; ns < 4; ns++) begin
            for (int k = 0; k < 2; k++) begin
                int p;
                int u;
                int g0;
                int g1;
                int bm;
                u  = ns >> 1;
                p  = 2 * (ns & 1) + k;
                g0 = u ^ (p >> 1) ^ (p & 1);
                g1 = u ^ (p & 1);
                bm = ((int'(c0) != g0) ? 1 : 0) + ((int'(c1) != g1) ? 1 : 0);
                cand[k] = (m_pm[p] + bm > PMAX) ? PMAX : m_pm[p] + bm;
            end
            if (cand[1] < cand[0]) begin
                d |= (1 << ns);
                npm[ns] = cand[1];
            end else begin
                npm[ns] = cand[0];
            end
        end
        mn = npm[0];
        best = 0;
        for (int i = 3; i >= 0; i--) begin
            if (npm[i] <= mn) begin
                mn = npm[i];
                best = i;
            end
        end
        for (int i = 0; i < 4; i++) m_pm[i] = npm[i] - mn;
        m_dec.push_back(d);
        if (m_dec.size() > TB) void'(m_dec.pop_front());
        if (m_cnt < TB) m_cnt++;
        if (m_cnt == TB) begin
            s = best;
            for (int j = 0; j < TB - 1; j++) begin
                int dd;
                dd = m_dec[m_dec.size() - 1 - j];
                s = 2 * (s & 1) + ((dd >> s) & 1);
            end
            m_out  = bit'(s >> 1);
            m_outv = 1'b1;
        end
        m_n++;
    endtask

    task automatic step(input bit v, input bit b);
        bit sym;
        int mn;
        in_valid = v;
        in_bit   = v ? b : 1'($urandom);
        @(posedge Clock);
        #1;
        m_outv = 1'b0;
        sym = 1'b0;
        if (v) begin
            if (!m_phase) begin
                m_c0 = b;
                m_phase = 1'b1;
            end else begin
                m_phase = 1'b0;
                model_symbol(m_c0, b);
                sym = 1'b1;
            end
        end
        check("out_valid", int'(out_valid), int'(m_outv));
        check("out", int'(out_bit), int'(m_out));
        if (out_valid === 1'b1) begin
            n_pulse++;
            seen_q.push_back(out_bit);
        end
        if (m_outv && (m_n - TB) < truth_q.size()) begin
            check("decoded_vs_sent", int'(out_bit), int'(truth_q[m_n - TB]));
        end
        if (sym) begin
            mn = PMAX;
            for (int i = 0; i < 4; i++) begin
                check("path_metric", int'(dut.pm_q[i]), m_pm[i]);
                if (int'(dut.pm_q[i]) < mn) mn = int'(dut.pm_q[i]);
            end
            check("min_metric_zero", mn, 0);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b0;
        #2;
        check("reset_out", int'(out_bit), 0);
        check("reset_out_valid", int'(out_valid), 0);
        @(posedge Clock);
        #1;
        reset = 1'b1;
        m_pm[0] = 0;
        for (int i = 1; i < 4; i++) m_pm[i] = PMAX;
        m_dec.delete();
        truth_q.delete();
        seen_q.delete();
        m_cnt = 0;
        m_n = 0;
        m_phase = 1'b0;
        m_c0 = 1'b0;
        m_out = 1'b0;
        m_outv = 1'b0;
        n_pulse = 0;
        enc1 = 1'b0;
        enc2 = 1'b0;
        for (int i = 0; i < 4; i++) check("reset_pm", int'(dut.pm_q[i]), m_pm[i]);
    endtask

    task automatic gap(input int gmax);
        if (gmax > 0) begin
            repeat ($urandom_range(1, gmax)) step(1'b0, 1'b0);
        end
    endtask

    task automatic send_info(input bit u, input bit f0, input bit f1, input int gmax);
        bit g0;
        bit g1;
        g0 = u ^ enc1 ^ enc2;
        g1 = u ^ enc2;
        enc2 = enc1;
        enc1 = u;
        truth_q.push_back(u);
        step(1'b1, g0 ^ f0);
        gap(gmax);
        step(1'b1, g1 ^ f1);
        gap(gmax);
    endtask

    task automatic known_seq(input bit flip, input int gmax);
        bit pat [6];
        bit first5 [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        first5 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send_info((i < 6) ? pat[i] : 1'b0, flip && (i == 1), 1'b0, gmax);
        end
        check("known_pulses", n_pulse, 5);
        for (int i = 0; i < 5 && i < seen_q.size(); i++) begin
            check("known_bit", int'(seen_q[i]), int'(first5[i]));
        end
        for (int i = 0; i < 20; i++) send_info(1'b0, 1'b0, 1'b0, gmax);
        check("known_pulses_total", n_pulse, 25);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_bit = 1'b0;
        n_pulse = 0;
        #3;

        // All zeros: first pulse one cycle after the 32nd coded bit.
        do_reset();
        for (int i = 0; i < 15; i++) send_info(1'b0, 1'b0, 1'b0, 0);
        check("zeros_no_early_pulse", n_pulse, 0);
        step(1'b1, 1'b0);
        check("zeros_not_after_g0", int'(out_valid), 0);
        step(1'b1, 1'b0);
        check("zeros_first_pulse", int'(out_valid), 1);
        for (int i = 0; i < 4; i++) send_info(1'b0, 1'b0, 1'b0, 0);
        check("zeros_pulses", n_pulse, 5);

        known_seq(1'b0, 0);
        known_seq(1'b1, 0);
        known_seq(1'b0, 5);

        // Reset in the middle of a symbol, then all-zeros behaviour again.
        do_reset();
        for (int i = 0; i < 3; i++) send_info(1'($urandom), 1'b0, 1'b0, 0);
        step(1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 20; i++) send_info(1'b0, 1'b0, 1'b0, 0);
        check("post_reset_pulses", n_pulse, 5);
        check("post_reset_outputs_zero", seen_q.sum() with (int'(item)), 0);

        // Random loopback, one channel error somewhere in each block of 20 symbols.
        do_reset();
        for (int blk = 0; blk < 500; blk++) begin
            int epos;
            bit ebit;
            epos = $urandom_range(3, 16);
            ebit = 1'($urandom);
            for (int j = 0; j < 20; j++) begin
                send_info(1'($urandom), (j == epos) && !ebit, (j == epos) && ebit, 0);
            end
        end
        check("loopback_pulses", n_pulse, 10000 - TB + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/viterbi_decoder.md
# viterbi_decoder

Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code, generators g0=111 and g1=101. It sits directly downstream of `vencoder`. It consumes the encoder's serial coded bit stream, one coded bit per valid cycle with g0 first, then g1. It emits the recovered information bits with fixed latency. Survivors use register exchange, so there is no traceback RAM.

## Interface

Parameters:
- `TB_DEPTH`, 16: survivor length in symbols; decode latency in symbols; minimum 4.
- `PM_W`, 6: path-metric width, unsigned; minimum 4.

Ports:
- `Clock`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in` carries a coded bit this cycle.
- `in`  input  1  serial coded bit; order per symbol is g0, then g1.
- `out`  output  1  decoded information bit.
- `out_valid`  output  1  one-cycle pulse; `out` is valid this cycle.

## Operation

- **Symbol assembly**
  - A 1-bit `phase` register resets to 0.
  - On a valid cycle with phase 0, `in` is latched as `c0` and phase becomes 1.
  - On a valid cycle with phase 1, the symbol {c0,in} completes, the ACS update fires at that edge, and phase returns to 0.
  - Cycles with `in_valid`=0 change nothing.
- **Trellis**
  - State s = {u[n-1], u[n-2]}.
  - Encoder outputs for input u: g0 = u^s[1]^s[0], g1 = u^s[0].
  - Next state = {u, s[1]}.
  - Each next state ns={u,a} has two predecessors: {a,0} and {a,1}.
- **Branch metric**: Hamming distance between the received {c0,c1} and the expected {g0,g1}; range 0..2.
- **ACS**
  - Candidate = pm[pred] + bm, saturating at 2^PM_W−1.
  - The smaller candidate wins.
  - On a tie, the predecessor with LSB 0 wins.
- **Normalization**: in the same update, the minimum of the four new metrics is subtracted from all four. After each update min(pm)=0 always holds.
- **Survivors**
  - Four TB_DEPTH-bit registers.
  - surv[ns] = {surv[winner][TB_DEPTH-2:0], u}.
- **Decision**
  - best = the state with the minimum new metric; on a tie, the lowest index.
  - The decoded bit is surv_new[best][TB_DEPTH-1], i.e. the bit for symbol n−TB_DEPTH+1.
- **Reset state**
  - pm[0]=0; pm[1..3]=2^PM_W−1.
  - Survivors 0, phase 0, symbol counter 0.
  - `out`=0, `out_valid`=0.
- **Symbol counter**: increments per completed symbol and saturates at TB_DEPTH. `out_valid` is enabled only once the count reaches TB_DEPTH, i.e. from symbol index TB_DEPTH−1 onward.

## Timing

- **Output registers**: `out` and `out_valid` are registered from the new survivors and metrics. They update at the same edge that completes a symbol, so they are visible in the cycle after the g1 bit was presented.
- **Latency**: decoded bit k appears with symbol k+TB_DEPTH−1. That is TB_DEPTH−1 symbols plus 1 cycle after its last coded bit.
- **Pulse shape**: `out_valid` is high for exactly one cycle per completed symbol once enabled. It is 0 on all other cycles. `out` holds its last value between pulses.
- **Back-to-back input**: with `in_valid` held high, one symbol completes every 2 cycles and `out_valid` pulses every 2 cycles. Gaps in `in_valid` of any length stretch this interval without loss.
- **Reset mid-stream**: `reset` low clears everything asynchronously, including a half-received symbol. After release, the first valid bit is treated as g0.
- **Metric saturation**: the saturating add guarantees no wrap. Because of normalization, a live metric never reaches 2^PM_W−1 except the initial unreachable-state value.

## Test plan

1. **All zeros**: reset, then 40 coded bits of 0 with `in_valid`=1. Expect 20 symbols and out_valid on symbols 15..19, with `out`=0 each time. The first pulse comes one cycle after the 32nd bit.
2. **Known sequence**: u=1,0,1,1,0,0 followed by 14 zeros, encoded as 11 10 00 01 01 11 then 00…. Expect the 5 emitted pulses to be `out`=1,0,1,1,0. Continue the stream to see the full sequence.
3. **Error correction**: same stream as scenario 2 with the third coded bit flipped, so the second symbol is 00 instead of 10. Expect decoded output identical to scenario 2.
4. **Gaps**: scenario 2 with `in_valid` dropped for 1–5 random cycles between bits and mid-symbol. Expect identical decoded bits, and `out_valid` pulses only after g1 bits.
5. **Reset mid-operation**: assert `reset` low after 7 bits, i.e. mid-symbol, for 1 cycle. Expect `out`=0 and `out_valid`=0 immediately, the counter restarted, and scenario 1 behaviour afterwards.
6. **Random loopback**: `vencoder` output feeding the decoder, 10k random bits, 1 injected error per 20 symbols. Expect zero decoded errors. Check that min(pm)=0 after every update and that no metric wraps.
